// File: rtl/ql_bus_timing_pkg.sv
// ql_timing_pkg: shared types and defaults for the QL bus-timing generator.
// Purpose : speed-select encoding, default geometry constants and a
//           constant-evaluable clog2 used to size the tick and reset
//           counters.
// Ports   : none (package).
package ql_timing_pkg;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'd0,
    SPD_X2     = 2'd1,
    SPD_X4     = 2'd2,
    SPD_MAX    = 2'd3
  } speed_e;

  localparam int DEF_DIV_W    = 3;
  localparam int DEF_SLOW_SH  = 2;
  localparam int DEF_TICK_DIV = 641;
  localparam int DEF_RST_LEN  = 4095;

  // Bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/ql_bus_timing_if.sv
// ql_bus_timing_if: bundle of the bus-timing generator's control inputs and
// clock-enable outputs.
// Signals : speed, rst_req (and bus_wait when QL_BUS_WAIT_EN is defined) go
//           into the generator; ce_p, ce_n, ce_vid, ce_sd, ce_tick,
//           duty_cycle, sub_cycle, cpu_cycle, ce_bus_p, ce_bus_n and
//           sys_reset come out of it.
// Modports: master = the timing generator, slave = its consumers.
// Config  : QL_BUS_WAIT_EN adds the bus_wait stall input.
interface ql_bus_timing_if #(
  parameter int SPEED_W = 2
);

  logic [SPEED_W-1:0] speed;
  logic               rst_req;
`ifdef QL_BUS_WAIT_EN
  logic               bus_wait;
`endif
  logic ce_p;
  logic ce_n;
  logic ce_vid;
  logic ce_sd;
  logic ce_tick;
  logic duty_cycle;
  logic sub_cycle;
  logic cpu_cycle;
  logic ce_bus_p;
  logic ce_bus_n;
  logic sys_reset;

`ifdef QL_BUS_WAIT_EN
  modport master (
    input  speed, rst_req, bus_wait,
    output ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, sub_cycle,
           cpu_cycle, ce_bus_p, ce_bus_n, sys_reset
  );
  modport slave (
    output speed, rst_req, bus_wait,
    input  ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, sub_cycle,
           cpu_cycle, ce_bus_p, ce_bus_n, sys_reset
  );
`else
  modport master (
    input  speed, rst_req,
    output ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, sub_cycle,
           cpu_cycle, ce_bus_p, ce_bus_n, sys_reset
  );
  modport slave (
    output speed, rst_req,
    input  ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, sub_cycle,
           cpu_cycle, ce_bus_p, ce_bus_n, sys_reset
  );
`endif

endinterface

// File: rtl/ql_bus_timing_reset_stretch.sv
// ql_reset_stretch: stretches a reset request into a sys_reset that lasts
// RST_LEN steps after the request drops.
// Ports : clk_sys, reset (async, active-high), rst_req_i (sync request,
//         reloads the count), step_i (one count per pulse), sys_reset_o
//         (registered, high while the count is non-zero).
module ql_reset_stretch
  import ql_timing_pkg::*;
#(
  parameter int RST_LEN = DEF_RST_LEN
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic rst_req_i,
  input  logic step_i,
  output logic sys_reset_o
);

  localparam int            CW   = clog2(RST_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(RST_LEN);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_reset_q;

  // A request always reloads, even when a step arrives in the same clock.
  always_comb begin
    cnt_d = cnt_q;
    if (rst_req_i)
      cnt_d = LOAD;
    else if (step_i && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q       <= LOAD;
      sys_reset_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      sys_reset_q <= (cnt_q != '0);
    end
  end

  assign sys_reset_o = sys_reset_q;

endmodule

// File: rtl/ql_bus_timing.sv
// ql_bus_timing: clock-enable and bus-timing generator for the QL core.
// Ports : clk_sys, reset (async, active-high) and a ql_bus_timing_if.master
//         carrying speed/rst_req in and the phase strobes (ce_p, ce_n,
//         ce_vid, ce_sd), low-rate tick, CPU duty/sub gating, the gated
//         bus strobes and the stretched sys_reset out.
// Config: QL_BUS_WAIT_EN adds bus_wait, which freezes the phase divider
//         just before the falling phase to stretch a bus cycle.
module ql_bus_timing
  import ql_timing_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int SLOW_SH  = DEF_SLOW_SH,
  parameter int SPEED_W  = 2,
  parameter int SD_SH    = 2,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int RST_LEN  = DEF_RST_LEN
) (
  input logic             clk_sys,
  input logic             reset,
  ql_bus_timing_if.master bus
);

  localparam int               DW        = DIV_W + SLOW_SH;
  localparam int               TW        = clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] PH_P      = '0;
  localparam logic [DIV_W-1:0] PH_N      = DIV_W'(1 << (DIV_W - 1));
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);

  logic [DW-1:0]      div_q, div_d;
  logic [SD_SH-1:0]   sd_q;
  logic [TW-1:0]      tick_q, tick_d;
  logic               ce_p_q, ce_n_q, ce_vid_q, ce_sd_q, ce_tick_q;
  logic               duty_q, duty_d, sub_q, sub_d;
  logic [SPEED_W-1:0] speed;
  logic [DIV_W-1:0]   phase;
  logic               stall, cpu_cycle, ce_bus_p;

  assign speed = bus.speed;
  assign phase = div_q[DIV_W-1:0];

  // The divider parks on the last phase before ce_n, so both ce_n and the
  // following ce_p slip by exactly the number of waited clocks.
`ifdef QL_BUS_WAIT_EN
  localparam logic [DIV_W-1:0] PH_HOLD = DIV_W'((1 << (DIV_W - 1)) - 1);
  assign stall = bus.bus_wait && (phase == PH_HOLD);
`else
  assign stall = 1'b0;
`endif

  // Slowdown: with `slow` = SLOW_SH - min(speed, SLOW_SH), the CPU owns only
  // the bus periods whose top `slow` divider bits are zero.
  always_comb begin
    int slow;
    div_d  = stall ? div_q : div_q + DW'(1);
    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    slow   = SLOW_SH - ((int'(speed) < SLOW_SH) ? int'(speed) : SLOW_SH);
    duty_d = 1'b1;
    for (int i = 0; i < SLOW_SH; i++)
      if ((i < slow) && div_q[DW-1-i]) duty_d = 1'b0;
    sub_d  = (speed == '0) ? ~sub_q : 1'b1;
  end

  // Gating changes only on bus-period or window boundaries, so a speed
  // change can never chop a ce_bus pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      sd_q      <= '0;
      tick_q    <= '0;
      ce_p_q    <= 1'b0;
      ce_n_q    <= 1'b0;
      ce_vid_q  <= 1'b0;
      ce_sd_q   <= 1'b0;
      ce_tick_q <= 1'b0;
      duty_q    <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      sd_q      <= sd_q + SD_SH'(1);
      tick_q    <= tick_d;
      ce_p_q    <= (phase == PH_P);
      ce_n_q    <= (phase == PH_N);
      ce_vid_q  <= (phase == PH_P);
      ce_sd_q   <= (sd_q == '0);
      ce_tick_q <= (tick_q == '0);
      if (phase == PH_P) duty_q <= duty_d;
      if (div_q == '0)   sub_q  <= sub_d;
    end
  end

  assign cpu_cycle      = duty_q & sub_q;
  assign ce_bus_p       = cpu_cycle & ce_p_q;
  assign bus.ce_p       = ce_p_q;
  assign bus.ce_n       = ce_n_q;
  assign bus.ce_vid     = ce_vid_q;
  assign bus.ce_sd      = ce_sd_q;
  assign bus.ce_tick    = ce_tick_q;
  assign bus.duty_cycle = duty_q;
  assign bus.sub_cycle  = sub_q;
  assign bus.cpu_cycle  = cpu_cycle;
  assign bus.ce_bus_p   = ce_bus_p;
  assign bus.ce_bus_n   = cpu_cycle & ce_n_q;

  ql_reset_stretch #(
    .RST_LEN (RST_LEN)
  ) u_reset_stretch (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .rst_req_i   (bus.rst_req),
    .step_i      (ce_bus_p),
    .sys_reset_o (bus.sys_reset)
  );

endmodule
